// File: rtl/chiptune_voice_engine.sv
// Multi-voice chiptune player: per-voice note sequencers over a writable song memory,
// saw/square/triangle oscillators, an averaging mixer and a PWM DAC.
module chiptune_voice_engine #(
  parameter int VOICES      = 2,
  parameter int PHASE_W     = 32,
  parameter int SAMPLE_W    = 12,
  parameter int DEPTH       = 64,
  parameter int DIV_LOG2    = 11,
  parameter int TICK_CYCLES = 2500000,
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = PHASE_W + 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play,
  input  logic                loop,
  input  logic [1:0]          wave_sel,
  input  logic                wr_en,
  input  logic [VW-1:0]       wr_voice,
  input  logic [AW-1:0]       wr_addr,
  input  logic [EW-1:0]       wr_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                pwm_out,
  output logic [VOICES-1:0]   gate,
  output logic                busy,
  output logic                done
);
  localparam int MIX_SH = (VOICES > 1) ? $clog2(VOICES) : 0;
  localparam int MIX_W  = SAMPLE_W + MIX_SH;
  localparam int UW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state_reg, state_next;
  logic                  load_song, done_next, run, unit_tick, sample_tick;
  logic [UW-1:0]         unit_reg;
  logic [DIV_LOG2-1:0]   div_reg;
  logic [SAMPLE_W-1:0]   pwm_cnt_reg;
  logic [VOICES-1:0]     fin_now, fin_adv;
  logic [SAMPLE_W-1:0]   voice_sample [VOICES];
  logic [MIX_W-1:0]      mix_sum;

  assign run         = (state_reg == RUN);
  assign busy        = run;
  assign unit_tick   = run && (unit_reg == UW'(TICK_CYCLES - 1));
  assign sample_tick = &div_reg;

  // Song end is detected on the unit tick that empties the last voice, so a loop
  // restarts on exactly that edge; an all-empty song falls through to HOLD.
  always_comb begin
    state_next = state_reg;
    load_song  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: if (play) begin
        state_next = RUN;
        load_song  = 1'b1;
      end
      RUN: begin
        if (!play) begin
          state_next = IDLE;
        end else if (&fin_now) begin
          state_next = HOLD;
          done_next  = 1'b1;
        end else if (unit_tick && (&fin_adv)) begin
          if (loop) begin
            load_song = 1'b1;
          end else begin
            state_next = HOLD;
            done_next  = 1'b1;
          end
        end
      end
      HOLD: if (!play) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      done         <= 1'b0;
      unit_reg     <= '0;
      div_reg      <= '0;
      pwm_cnt_reg  <= '0;
      pwm_out      <= 1'b0;
      sample_out   <= MID;
      sample_valid <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done         <= done_next;
      unit_reg     <= (run && !unit_tick) ? unit_reg + UW'(1) : '0;
      div_reg      <= div_reg + DIV_LOG2'(1);
      pwm_cnt_reg  <= pwm_cnt_reg + SAMPLE_W'(1);
      pwm_out      <= (pwm_cnt_reg < sample_out);
      sample_valid <= sample_tick;
      if (sample_tick) sample_out <= SAMPLE_W'(mix_sum >> MIX_SH);
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       idx_reg, nxt_idx;
    logic [7:0]          rem_reg, rem_adv, nxt_dur, first_dur, cur_gap;
    logic [PHASE_W-1:0]  phase_reg, phase_new, cur_inc;
    logic [SAMPLE_W-1:0] p, wave;
    logic                last;

    assign nxt_idx   = idx_reg + AW'(1);
    assign cur_inc   = mem[idx_reg][EW-1:16];
    assign cur_gap   = mem[idx_reg][7:0];
    assign nxt_dur   = mem[nxt_idx][15:8];
    assign first_dur = mem[0][15:8];
    assign last      = (idx_reg == AW'(DEPTH - 1));

    // rem == 0 marks a finished voice: reached an end marker or ran off the table.
    always_comb begin
      rem_adv = rem_reg - 8'd1;
      if (rem_reg == 8'd0)      rem_adv = 8'd0;
      else if (rem_reg == 8'd1) rem_adv = last ? 8'd0 : nxt_dur;
    end

    assign fin_now[gi] = (rem_reg == 8'd0);
    assign fin_adv[gi] = (rem_adv == 8'd0);
    assign gate[gi]    = run && (rem_reg > cur_gap) && (cur_inc != '0);
    assign phase_new   = phase_reg + cur_inc;
    assign p           = phase_new[PHASE_W-1 -: SAMPLE_W];

    always_comb begin
      case (wave_sel)
        2'b01:   wave = {SAMPLE_W{p[SAMPLE_W-1]}};
        2'b10:   wave = p[SAMPLE_W-1] ? ~{p[SAMPLE_W-2:0], 1'b0} : {p[SAMPLE_W-2:0], 1'b0};
        default: wave = p;
      endcase
    end

    assign voice_sample[gi] = gate[gi] ? wave : MID;

    always_ff @(posedge clk) begin
      if (wr_en && !busy && ((VOICES == 1) || (wr_voice == VW'(gi)))) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        idx_reg   <= '0;
        rem_reg   <= '0;
        phase_reg <= '0;
      end else if (load_song) begin
        idx_reg   <= '0;
        rem_reg   <= first_dur;
        phase_reg <= '0;
      end else begin
        if (unit_tick && (rem_reg != 8'd0)) begin
          rem_reg <= rem_adv;
          if (rem_reg == 8'd1) idx_reg <= nxt_idx;
        end
        if (sample_tick && gate[gi]) phase_reg <= phase_new;
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < VOICES; i++) mix_sum = mix_sum + MIX_W'(voice_sample[i]);
  end
endmodule
